// File: rtl/fp_add_align.sv
// Floating-point adder front end: unpack/order, align/add, carry fix.
// Three-stage valid/ready pipeline whose stages all advance on one shared enable.
module fp_add_align #(
  parameter int X         = 32,
  parameter int expo_bits = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [X-1:0]           a,
  input  logic [X-1:0]           b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [expo_bits-1:0]   out_exp,
  output logic [X-expo_bits:0]   out_mant,
  output logic                   out_zero,
  output logic                   out_special
);

  localparam int F  = X - expo_bits - 1;
  localparam int MW = F + 2;
  localparam logic [expo_bits-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic                 sign;
    logic [expo_bits-1:0] exp;
    logic [MW-1:0]        mant;
    logic                 zero;
    logic                 special;
  } res_t;

  // Right shift that flushes to zero once every significand bit is gone.
  function automatic logic [MW-1:0] align(input logic [MW-1:0] m,
                                          input logic [expo_bits-1:0] d);
    if (32'(d) >= 32'(MW)) align = '0;
    else                   align = m >> d;
  endfunction

  // Fold a carry-out back into range; an exponent reaching all-ones saturates to infinity.
  function automatic res_t fix_carry(input logic [MW-1:0] sum,
                                     input logic [expo_bits-1:0] exp_l,
                                     input logic sign_l);
    res_t r;
    r = '0;
    if (sum == '0) begin
      r.zero = 1'b1;
    end else if (sum[MW-1]) begin
      r.sign = sign_l;
      r.exp  = exp_l + expo_bits'(1);
      if (r.exp == EXP_MAX) r.special = 1'b1;
      else                  r.mant    = sum >> 1;
    end else begin
      r.sign = sign_l;
      r.exp  = exp_l;
      r.mant = sum;
    end
    return r;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic                 a_ge_b, a_inf, b_inf;
  logic [X-1:0]         op_l, op_s;
  logic [expo_bits-1:0] raw_l, raw_s, eff_l, eff_s;

  always_comb begin
    a_ge_b = a[X-2:0] >= b[X-2:0];
    op_l   = a_ge_b ? a : b;
    op_s   = a_ge_b ? b : a;
    raw_l  = op_l[X-2:F];
    raw_s  = op_s[X-2:F];
    eff_l  = (raw_l == '0) ? expo_bits'(1) : raw_l;
    eff_s  = (raw_s == '0) ? expo_bits'(1) : raw_s;
    a_inf  = &a[X-2:F];
    b_inf  = &b[X-2:F];
  end

  logic                 vld_p0, vld_p1;
  logic                 sign_p0, sub_p0, spec_p0, spec_sign_p0;
  logic [expo_bits-1:0] exp_p0, dist_p0;
  logic [MW-1:0]        m_l_p0, m_s_p0;
  logic                 sign_p1, spec_p1, spec_sign_p1;
  logic [expo_bits-1:0] exp_p1;
  logic [MW-1:0]        sum_p1, m_s_al;
  res_t                 res_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      out_valid <= vld_p1;
    end
  end

  // Stage 1 -> p0: unpacked, magnitude-ordered operands.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p0      <= op_l[X-1];
      sub_p0       <= op_l[X-1] ^ op_s[X-1];
      exp_p0       <= eff_l;
      dist_p0      <= eff_l - eff_s;
      m_l_p0       <= {1'b0, |raw_l, op_l[F-1:0]};
      m_s_p0       <= {1'b0, |raw_s, op_s[F-1:0]};
      spec_p0      <= a_inf | b_inf;
      spec_sign_p0 <= a_inf ? a[X-1] : b[X-1];
    end
  end

  assign m_s_al = align(m_s_p0, dist_p0);

  // Stage 2 -> p1: aligned sum; L >= S keeps the difference non-negative.
  always_ff @(posedge clk) begin
    if (adv) begin
      sum_p1       <= sub_p0 ? (m_l_p0 - m_s_al) : (m_l_p0 + m_s_al);
      sign_p1      <= sign_p0;
      exp_p1       <= exp_p0;
      spec_p1      <= spec_p0;
      spec_sign_p1 <= spec_sign_p0;
    end
  end

  always_comb begin
    res_p1 = fix_carry(sum_p1, exp_p1, sign_p1);
    if (spec_p1) begin
      res_p1         = '0;
      res_p1.sign    = spec_sign_p1;
      res_p1.exp     = EXP_MAX;
      res_p1.special = 1'b1;
    end
  end

  // Stage 3 -> outputs: carry-fixed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      {out_sign, out_exp, out_mant, out_zero, out_special} <= '0;
    end else if (adv) begin
      {out_sign, out_exp, out_mant, out_zero, out_special} <= res_p1;
    end
  end

endmodule

// File: tb/tb_fp_add_align.sv
// Self-checking bench for fp_add_align: directed vectors, backpressure, reset, random traffic
// scored against an arithmetic reference model.
module tb_fp_add_align;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b;
  logic        out_sign, out_zero, out_special;
  logic [7:0]  out_exp;
  logic [24:0] out_mant;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic        zero;
    logic        special;
  } res_t;

  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];
  res_t obs;

  fp_add_align #(.X(32), .expo_bits(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_zero(out_zero), .out_special(out_special)
  );

  always #5 clk = ~clk;
  assign obs = {out_sign, out_exp, out_mant, out_zero, out_special};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic res_t mk(input logic s, input logic [7:0] e, input logic [24:0] m,
                              input logic z, input logic sp);
    return {s, e, m, z, sp};
  endfunction

  // Reference: real-number style add of the two significands at the larger exponent.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    logic [31:0] lo, sm;
    longint      sl, ss, sum;
    int          el, es, d;
    r = '0;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
      r.special = 1'b1;
      r.exp     = 8'hFF;
      r.sign    = (x[30:23] == 8'hFF) ? x[31] : y[31];
      return r;
    end
    if (y[30:0] > x[30:0]) begin lo = y; sm = x; end
    else                   begin lo = x; sm = y; end
    sl = longint'(lo[22:0]) + ((lo[30:23] != 0) ? 64'd8388608 : 64'd0);
    ss = longint'(sm[22:0]) + ((sm[30:23] != 0) ? 64'd8388608 : 64'd0);
    el = (lo[30:23] == 0) ? 1 : int'(lo[30:23]);
    es = (sm[30:23] == 0) ? 1 : int'(sm[30:23]);
    d  = el - es;
    if (d >= 25) ss = 0;
    else         ss = ss / (64'd1 << d);
    sum = (lo[31] != sm[31]) ? (sl - ss) : (sl + ss);
    if (sum == 0) begin
      r.zero = 1'b1;
      return r;
    end
    if (sum >= 64'd16777216) begin
      sum = sum / 2;
      el  = el + 1;
    end
    r.sign = lo[31];
    if (el >= 255) begin
      r.special = 1'b1;
      r.exp     = 8'hFF;
      return r;
    end
    r.exp  = 8'(el);
    r.mant = 25'(sum);
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 8)
      0:       r[30:23] = 8'hFF;
      1:       r[30:23] = 8'h00;
      2:       r[30:23] = 8'hFE;
      3:       r[30:0]  = 31'd0;
      default: r[30:23] = 8'(32'd120 + $urandom % 16);
    endcase
    return r;
  endfunction

  // Monitor: scoreboard every handshake, and require stalled outputs to hold.
  initial begin
    res_t prev, want;
    logic prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", 64'(obs), 64'(prev));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
          else begin
            want = sb.pop_front();
            check("result", 64'(obs), 64'(want));
          end
        end
        if (in_valid && in_ready) sb.push_back(model(a, b));
        prev_stall = out_valid && !out_ready;
        prev       = obs;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input res_t want);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    @(negedge clk); check({tag, "_lat2"}, 64'(out_valid), 64'(0));
    @(negedge clk); check({tag, "_lat3"}, 64'(out_valid), 64'(1));
    check(tag, 64'(obs), 64'(want));
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; a = x; b = y;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    check("send_accept", 64'(got), 64'(1));
  endtask

  initial begin
    logic [31:0] bp_a[4], bp_b[4];
    res_t        held;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_outputs",   64'(obs),       64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    directed("carry",     32'h3F800000, 32'h3F800000, mk(1'b0, 8'd128, 25'h0800000, 1'b0, 1'b0));
    directed("add",       32'h3F800000, 32'h3F000000, mk(1'b0, 8'd127, 25'h0C00000, 1'b0, 1'b0));
    directed("sub",       32'h3F800000, 32'hBF400000, mk(1'b0, 8'd127, 25'h0200000, 1'b0, 1'b0));
    directed("zero",      32'h3F800000, 32'hBF800000, mk(1'b0, 8'd0,   25'h0,       1'b1, 1'b0));
    directed("zero_tie",  32'hBF800000, 32'h3F800000, mk(1'b0, 8'd0,   25'h0,       1'b1, 1'b0));
    directed("far",       32'h3F800000, 32'h30800000, mk(1'b0, 8'd127, 25'h0800000, 1'b0, 1'b0));
    directed("inf",       32'h7F800000, 32'h3F800000, mk(1'b0, 8'hFF,  25'h0,       1'b0, 1'b1));
    directed("neg_inf_b", 32'h3F800000, 32'hFF800000, mk(1'b1, 8'hFF,  25'h0,       1'b0, 1'b1));
    directed("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, mk(1'b0, 8'hFF,  25'h0,       1'b0, 1'b1));
    directed("subnormal", 32'h00000001, 32'h00000001, mk(1'b0, 8'd1,   25'h0000002, 1'b0, 1'b0));
    directed("neg_sub",   32'hC0000000, 32'h3F800000, mk(1'b1, 8'd128, 25'h0400000, 1'b0, 1'b0));

    // Backpressure: three fill the pipe, the fourth waits until out_ready returns.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 32'h3F800000 + 32'(i) * 32'h00100000;
      bp_b[i] = 32'h40000000 + 32'(i) * 32'h00080000;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(bp_a[i], bp_b[i]);
    in_valid = 1'b1; a = bp_a[3]; b = bp_b[3];
    @(negedge clk);
    check("bp_in_ready",  64'(in_ready),  64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_head",      64'(obs),       64'(model(bp_a[0], bp_b[0])));
    held = obs;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold",       64'(obs),      64'(held));
      check("bp_ready_low",  64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready),  64'(1));
    check("bp_run0",          64'(out_valid), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (i > 1) @(posedge clk);
      @(negedge clk);
      check("bp_run", 64'(out_valid), 64'(1));
    end
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'(0));
    check("bp_sb_empty", 64'(sb.size()), 64'(0));

    // Reset with two transactions in flight.
    @(posedge clk); #1;
    send(32'h3F800000, 32'h3F800000);
    send(32'h40400000, 32'h3F800000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_ready", 64'(in_ready),  64'(1));
    repeat (5) begin
      @(negedge clk);
      check("mid_rst_stale", 64'(out_valid), 64'(0));
    end

    // Random traffic with random backpressure, bubbles and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 3) != 0;
      rst       = ($urandom % 500) == 0;
      a = rand_op();
      case ($urandom % 4)
        0, 1:    b = rand_op();
        2:       b = {~a[31], 8'(a[30:23] + 8'($urandom % 3)), 23'($urandom)};
        default: b = a ^ 32'h80000000;
      endcase
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'(0));
    check("final_idle",     64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_align.md
# fp_add_align

Pipelined front end of the floating-point adder. It accepts two packed IEEE-style operands and does the following:
- unpacks both operands and orders them by magnitude;
- aligns the smaller operand;
- adds or subtracts the significands;
- folds any carry-out back into range.

It drives the adder normalizer directly: mantissa bit 23 (for X=32) is the leading-one position or below, and bit 24 is always 0 on output. Three-stage valid/ready pipeline with backpressure.

## Interface
- X, 32, total operand width
- expo_bits, 8, exponent width; fraction width F = X-expo_bits-1 (23)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a, b  in  X each  packed operands {sign, exponent, fraction}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sign  out  1  result sign
- out_exp  out  expo_bits  result exponent (feeds normalizer exp_in)
- out_mant  out  F+2 (25)  result significand [F+1:0] (feeds normalizer mant_in)
- out_zero  out  1  exact-zero result
- out_special  out  1  Inf/NaN operand or exponent overflow

## Operation
- Clock and reset: one clock. Reset is synchronous and active-high.
- Pipeline advance: enable `adv = !out_valid || out_ready`. `in_ready = adv`. All three stages advance together on `adv`, and stage valids shift. No bubbles are collapsed.
- Stage 1, unpack and order:
  - Hidden bit is 1 if the exponent ≠ 0. If the exponent = 0, hidden bit is 0 and the effective exponent is 1.
  - Magnitude compare uses {exponent, fraction}. L = larger operand, S = smaller. On a tie, L = a.
  - `d = expL − expS` (unsigned). `op_sub = signL ^ signS`.
- Stage 2, align and add:
  - `mS = {1'b0, hidS, fracS} >> d`. If d ≥ F+2, mS = 0.
  - Bits shifted out are discarded (truncation, no guard/sticky).
  - `sum = mL ± mS`, F+2 bits wide. Because L ≥ S, the subtraction is never negative.
- Stage 3, carry fix:
  - If `sum[F+1]`: out_mant = sum >> 1 and out_exp = expL + 1.
  - Otherwise: out_mant = sum and out_exp = expL.
  - out_sign = signL.
- Zero result: if sum = 0, out_zero = 1, out_sign = 0, out_mant = 0, out_exp = 0.
- Special results, which take precedence over zero:
  - Either input exponent is all-ones: out_special = 1, out_exp = all-ones, out_mant = 0, out_sign = sign of a if a is special, else sign of b.
  - A carry increment reaches all-ones: out_special = 1, out_mant = 0 (overflow to infinity).
- Out of scope: NaN payload, rounding and sticky bits.

## Timing
- Latency: 3 cycles from in_valid && in_ready to out_valid, with out_ready held high.
- Throughput: 1 result per cycle.
- Reset: out_valid = 0, all internal valids = 0, out_sign/out_exp/out_mant/out_zero/out_special = 0, in_ready = 1 (since out_valid = 0).
- Stall: while out_valid && !out_ready, all outputs and all stage registers hold and in_ready = 0. The pipeline holds at most 3 transactions in flight.
- Out_valid with out_ready on the same cycle: the result is consumed and the pipeline advances in that same cycle (no dead cycle).
- Reset while data is in flight: all in-flight transactions are dropped. The next cycle shows out_valid = 0 and in_ready = 1.
- Ordering: results leave in input order. No transaction is dropped or duplicated under any out_ready pattern.
- Invalid inputs: operands presented with in_valid = 0 must not alter valid results.

## Test plan
- Carry case: 0x3F800000 + 0x3F800000 (1.0 + 1.0) -> out_exp 128, out_mant 0x0800000, out_sign 0, out_valid 3 cycles later.
- Simple add: 0x3F800000 + 0x3F000000 (1.0 + 0.5) -> out_exp 127, out_mant 0x0C00000.
- Subtraction and exact zero:
  - 0x3F800000 + 0xBF400000 (1.0 − 0.75) -> out_exp 127, out_mant 0x0200000, sign 0 (normalizer then shifts by 2).
  - 0x3F800000 + 0xBF800000 -> out_zero 1, all other outputs 0.
- Large exponent difference and specials:
  - 0x3F800000 + 0x30800000 (exponent difference 30) -> out_mant 0x0800000, exp 127.
  - 0x7F800000 + 0x3F800000 -> out_special 1, exp 0xFF.
  - 0x7F7FFFFF + 0x7F7FFFFF -> out_special 1 (overflow).
- Backpressure: hold out_ready = 0 and issue 4 back-to-back pairs -> in_ready falls after 3 are accepted and outputs hold steady. Then release out_ready -> 4 results in order on consecutive cycles.
- Reset mid-stream: assert rst for 1 cycle with 2 transactions in flight -> out_valid = 0 on the next cycle and no stale result appears afterwards.
